sample_fifo_bram: RTL and testbench
===================================

# sample_fifo_bram

Block-RAM-backed 32-bit sample FIFO between the UART 32-bit word assembler and the FIR filter datapath. It accepts one assembled sample per write-enable pulse and reports full back to the assembler so the assembler holds its word. The FIR side reads samples with a one-cycle registered read latency. Occupancy and half-full flags let the control logic start filtering once enough samples are buffered.

## Interface
- DATA_W, 32, sample width in bits
- DEPTH, 1024, number of entries; must be a power of two and at least 4
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- i_clk  in  1  system clock; all logic on the rising edge
- i_rstn  in  1  synchronous, active-low reset
- i_wr_en  in  1  write strobe; single-cycle pulse from the assembler's data-valid
- i_wr_data  in  DATA_W  sample to write
- o_full  out  1  FIFO full; drives the assembler's FIFO-full input
- i_rd_en  in  1  read request from the FIR stage
- o_rd_data  out  DATA_W  read data; valid when o_rd_valid=1
- o_rd_valid  out  1  one-cycle pulse, one cycle after an accepted read
- o_empty  out  1  FIFO empty
- o_half_full  out  1  occupancy >= DEPTH/2
- o_count  out  ADDR_W+1  current occupancy, 0..DEPTH
- o_ovf_cnt  out  16  rejected writes/reads counter (only with the macro, see Configuration)

## Operation
- Write and read pointers are ADDR_W+1 bits wide. The MSB is the wrap bit. Memory is addressed with the low ADDR_W bits.
- Write acceptance: wr_ok = i_wr_en & ~o_full. This uses the registered o_full, so a write while full is dropped even if a read occurs in the same cycle.
- Read acceptance: rd_ok = i_rd_en & ~o_empty. This uses the registered o_empty, so a read while empty is ignored even if a write occurs in the same cycle.
- Each accepted write stores to mem[wptr] and increments wptr. Each accepted read fetches mem[rptr] and increments rptr. Pointers wrap naturally modulo 2*DEPTH.
- o_count updates every cycle by (+1 on wr_ok) and (−1 on rd_ok). A simultaneous accepted read and write leaves o_count unchanged.
- o_full = (o_count_next == DEPTH).
- o_empty = (o_count_next == 0).
- o_half_full = (o_count_next >= DEPTH/2).
- All flags are registered from the next-state count.
- Memory contents are never cleared. Reset only clears pointers, flags, and counters.
- Reset mid-operation discards all stored samples and drops any pending o_rd_valid on the next edge.
- The block has no FSM. Its behaviour is fully defined by pointer/count arithmetic.

## Timing
- Reset values:
  - o_full=0, o_empty=1, o_half_full=0, o_count=0
  - o_rd_valid=0, o_rd_data=0, o_ovf_cnt=0
- Write-to-flag latency: 1 cycle. A write at edge N is reflected in o_count/o_empty at edge N+1.
- Write-to-readable: a sample written at edge N may be read at edge N+1 (o_empty low). Its data appears with o_rd_valid at edge N+2.
- Read latency: i_rd_en accepted at edge N → o_rd_data/o_rd_valid registered at edge N+1. o_rd_data holds its value until the next accepted read.
- Back-to-back reads every cycle are supported: one sample per cycle.
- The full flag rises on the same edge that stores the DEPTH-th sample. The assembler sees it before its next word, which is at least 4 UART bytes later.

## Configuration
- SAMPLE_FIFO_OVF_CNT_EN defined:
  - o_ovf_cnt counts dropped writes (i_wr_en & o_full) plus ignored reads (i_rd_en & o_empty).
  - The counter saturates at 16'hFFFF and clears on reset.
  - If both a dropped write and an ignored read occur in one cycle, the counter adds 1, not 2.
- SAMPLE_FIFO_OVF_CNT_EN undefined:
  - o_ovf_cnt is tied to 0 and no counter logic is generated.
  - The port is always present.

## Structure
- Shared package sample_pkg holds:
  - SAMPLE_W = 32
  - FIFO_DEPTH_DEFAULT = 1024
  - the sample_t typedef (logic [SAMPLE_W-1:0])
- Sub-module sample_bram_sdp:
  - simple dual-port RAM, DEPTH × DATA_W
  - one write port and one registered read port on i_clk
  - no reset, so it infers block RAM
- The top level holds the pointers, count, flags, overflow counter, and the o_rd_valid register.

## Test plan
All scenarios use DEPTH=8.
- Reset then idle → o_empty=1, o_full=0, o_count=0, o_rd_valid=0 for 10 cycles.
- Write 0x11111111..0x88888888 on 8 consecutive cycles → o_half_full rises after the 4th write, o_full after the 8th, o_count=8. A 9th write of 0xDEADBEEF is dropped (o_ovf_cnt=1 with the macro).
- From full, read 8 times back-to-back → o_rd_data returns 0x11111111..0x88888888 in order, each one cycle after its i_rd_en. o_empty=1 after the 8th read. A 9th read produces no o_rd_valid.
- Simultaneous write and read at count=3 → o_count stays 3 and the oldest word is returned. At count=0, a simultaneous write+read stores the write, ignores the read, and sets count to 1.
- Write 20 and read 20 interleaved (pointer wrap twice) → data order preserved, o_count never exceeds 8 or goes negative.
- Assert i_rstn=0 at count=5 with a read in flight → next cycle o_count=0, o_empty=1, o_rd_valid=0. A subsequent write 0xA5A5A5A5 then read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared sample types and sizing for the UART-to-FIR sample path.
// Consumed by the sample FIFO and its RAM.
package sample_pkg;

  localparam int SAMPLE_W           = 32;
  localparam int FIFO_DEPTH_DEFAULT = 1024;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo_bram_if.sv
// Sample FIFO bus: assembler write side, FIR read side, status flags.
// master = FIFO user, slave = FIFO.
interface sample_fifo_bram_if
  import sample_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = FIFO_DEPTH_DEFAULT
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              i_wr_en;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_full;
  logic              i_rd_en;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_empty;
  logic              o_half_full;
  logic [ADDR_W:0]   o_count;
  logic [15:0]       o_ovf_cnt;

  modport master (
    output i_wr_en,
    output i_wr_data,
    output i_rd_en,
    input  o_full,
    input  o_rd_data,
    input  o_rd_valid,
    input  o_empty,
    input  o_half_full,
    input  o_count,
    input  o_ovf_cnt
  );

  modport slave (
    input  i_wr_en,
    input  i_wr_data,
    input  i_rd_en,
    output o_full,
    output o_rd_data,
    output o_rd_valid,
    output o_empty,
    output o_half_full,
    output o_count,
    output o_ovf_cnt
  );

endinterface

// File: rtl/sample_bram_sdp.sv
// Simple dual-port sample RAM, one write port, one registered read port.
// No reset so the array maps onto block RAM.
module sample_bram_sdp
  import sample_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = FIFO_DEPTH_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_rd_en,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [DATA_W-1:0]          o_rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/sample_fifo_bram.sv
// BRAM-backed sample FIFO between UART word assembler and FIR datapath.
// Optional overflow counter: define SAMPLE_FIFO_OVF_CNT_EN.
module sample_fifo_bram
  import sample_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = FIFO_DEPTH_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  sample_fifo_bram_if.slave   bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] HALF_CNT = (ADDR_W+1)'(DEPTH / 2);

  logic [ADDR_W:0]   wptr, rptr;
  logic [ADDR_W:0]   wptr_nxt, rptr_nxt;
  logic [ADDR_W:0]   cnt_nxt, cnt_q;
  logic              full_q, empty_q, half_q;
  logic              vld_q, seen_q;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] ram_q;

  // Gated by reset so a reset cycle neither stores nor fetches.
  assign wr_ok = bus.i_wr_en & ~full_q & i_rstn;
  assign rd_ok = bus.i_rd_en & ~empty_q & i_rstn;

  assign wptr_nxt = wptr + {{ADDR_W{1'b0}}, wr_ok};
  assign rptr_nxt = rptr + {{ADDR_W{1'b0}}, rd_ok};
  assign cnt_nxt  = wptr_nxt - rptr_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      half_q  <= 1'b0;
      vld_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == FULL_CNT);
      empty_q <= (cnt_nxt == '0);
      half_q  <= (cnt_nxt >= HALF_CNT);
      vld_q   <= rd_ok;
      seen_q  <= seen_q | rd_ok;
    end
  end

  sample_bram_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (wr_ok),
    .i_wr_addr (wptr[ADDR_W-1:0]),
    .i_wr_data (bus.i_wr_data),
    .i_rd_en   (rd_ok),
    .i_rd_addr (rptr[ADDR_W-1:0]),
    .o_rd_data (ram_q)
  );

  // RAM output is unreset; mask it until the first read after reset.
  assign bus.o_rd_data   = seen_q ? ram_q : '0;
  assign bus.o_rd_valid  = vld_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_half_full = half_q;
  assign bus.o_count     = cnt_q;

`ifdef SAMPLE_FIFO_OVF_CNT_EN
  logic [15:0] ovf_q;
  logic        ovf_ev;

  assign ovf_ev = (bus.i_wr_en & full_q) | (bus.i_rd_en & empty_q);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ovf_q <= '0;
    end else if (ovf_ev && ovf_q != 16'hFFFF) begin
      ovf_q <= ovf_q + 16'd1;
    end
  end

  assign bus.o_ovf_cnt = ovf_q;
`else
  assign bus.o_ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_sample_fifo_bram.sv
// Scoreboard bench for sample_fifo_bram at DEPTH=8.
// Reference queue models contents; read data checked against it.
module tb_sample_fifo_bram;
  import sample_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic i_clk;
  logic i_rstn;

  sample_fifo_bram_if #(.DATA_W(SAMPLE_W), .DEPTH(DEPTH)) bus ();

  sample_fifo_bram #(
    .DATA_W (SAMPLE_W),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int      n_chk = 0;
  int      n_err = 0;
  sample_t mq[$];
  sample_t exp_q[$];
  sample_t last_rd;
  int      ovf_m;
  int      max_seen;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_flags();
    int c;
    c = mq.size();
    check("count", 64'(bus.o_count), 64'(c));
    check("empty", 64'(bus.o_empty), 64'(c == 0));
    check("full", 64'(bus.o_full), 64'(c == DEPTH));
    check("half", 64'(bus.o_half_full), 64'(c >= DEPTH / 2));
    check("ovf", 64'(bus.o_ovf_cnt), 64'(ovf_m));
    if (int'(bus.o_count) > max_seen) max_seen = int'(bus.o_count);
  endtask

  task automatic step(input logic wr, input sample_t wd, input logic rd);
    logic wacc, racc;
    int   c;
    c    = mq.size();
    wacc = wr && (c != DEPTH);
    racc = rd && (c != 0);
`ifdef SAMPLE_FIFO_OVF_CNT_EN
    if (((wr && c == DEPTH) || (rd && c == 0)) && ovf_m < 16'hFFFF)
      ovf_m++;
`endif
    if (racc) exp_q.push_back(mq.pop_front());
    if (wacc) mq.push_back(wd);
    bus.i_wr_en   = wr;
    bus.i_wr_data = wd;
    bus.i_rd_en   = rd;
    @(posedge i_clk);
    #1;
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    check("rd_valid", 64'(bus.o_rd_valid), 64'(racc));
    if (racc) begin
      if (exp_q.size() != 0) last_rd = exp_q.pop_front();
      check("rd_data", 64'(bus.o_rd_data), 64'(last_rd));
    end else begin
      check("rd_hold", 64'(bus.o_rd_data), 64'(last_rd));
    end
    check_flags();
  endtask

  task automatic reset_model();
    mq.delete();
    exp_q.delete();
    last_rd = '0;
    ovf_m   = 0;
  endtask

  initial begin
    sample_t d;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_data = '0;
    bus.i_rd_en   = 1'b0;
    i_rstn        = 1'b0;
    max_seen      = 0;
    reset_model();
    repeat (3) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    check("rst_rd_data", 64'(bus.o_rd_data), 64'd0);
    check("rst_rd_valid", 64'(bus.o_rd_valid), 64'd0);
    check_flags();

    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);

    for (int i = 1; i <= DEPTH; i++) step(1'b1, sample_t'(i) * 32'h11111111, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0);

    for (int i = 0; i <= DEPTH; i++) step(1'b0, '0, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b1, 32'hC000_0000 + i, 1'b0);
    step(1'b1, 32'hC000_0003, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b1, 32'hB0B0_0001, 1'b1);
    step(1'b0, '0, 1'b1);

    step(1'b1, 32'h5000_0000, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b1, 32'h5000_0000 + i, 1'b1);
    step(1'b0, '0, 1'b1);

    for (int i = 0; i < 120; i++) begin
      d = $urandom;
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 120; i++) begin
      d = $urandom;
      step(1'($urandom_range(0, 3) == 0), d, 1'($urandom_range(0, 1)));
    end
    check("max_count", 64'(max_seen <= DEPTH), 64'd1);

    while (mq.size() != 0) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h7700_0000 + i, 1'b0);
    bus.i_rd_en = 1'b1;
    i_rstn      = 1'b0;
    @(posedge i_clk);
    #1;
    bus.i_rd_en = 1'b0;
    i_rstn      = 1'b1;
    reset_model();
    check("mid_rst_valid", 64'(bus.o_rd_valid), 64'd0);
    check("mid_rst_data", 64'(bus.o_rd_data), 64'd0);
    check_flags();
    step(1'b1, 32'hA5A5A5A5, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
